// File: rtl/axi4lite_bus_arbiter_if.sv
// AXI4-Lite channel bundle shared by the arbiter's upstream and downstream ports.
// master drives requests/ready-for-response; slave drives ready-for-request/responses.
interface axi4lite_if #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [2:0]              awprot;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid;
   logic                    wready;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [2:0]              arprot;
   logic                    arvalid;
   logic                    arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axi4lite_bus_arbiter.sv
// Round-robin share of one AXI4-Lite slave between two masters, one transaction in flight.
// One IDLE arbitration cycle per transaction; non-owner is stalled (ready=0) until granted.
module axi4lite_bus_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   axi4lite_if.slave   m0_bus,
   axi4lite_if.slave   m1_bus,
   axi4lite_if.master  mem_bus,
   output logic        busy,
   output logic        owner
);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t state_q, state_d;
   logic   owner_q, owner_d;
   logic   ar_done_q, ar_done_d;
   logic   aw_done_q, aw_done_d;
   logic   w_done_q, w_done_d;

   logic [1:0] rd_req, wr_req, req;
   logic       grant;

   assign rd_req = {m1_bus.arvalid, m0_bus.arvalid};
   assign wr_req = {m1_bus.awvalid | m1_bus.wvalid, m0_bus.awvalid | m0_bus.wvalid};
   assign req    = rd_req | wr_req;
   // On a tie the port that did not own the last transaction wins.
   assign grant  = (req == 2'b11) ? ~owner_q : req[1];

   // Owner's request-side signals
   logic                    own_arvalid, own_awvalid, own_wvalid, own_rready, own_bready;
   logic [ADDR_WIDTH-1:0]   own_araddr, own_awaddr;
   logic [2:0]              own_arprot, own_awprot;
   logic [DATA_WIDTH-1:0]   own_wdata;
   logic [DATA_WIDTH/8-1:0] own_wstrb;

   assign own_arvalid = owner_q ? m1_bus.arvalid : m0_bus.arvalid;
   assign own_araddr  = owner_q ? m1_bus.araddr  : m0_bus.araddr;
   assign own_arprot  = owner_q ? m1_bus.arprot  : m0_bus.arprot;
   assign own_awvalid = owner_q ? m1_bus.awvalid : m0_bus.awvalid;
   assign own_awaddr  = owner_q ? m1_bus.awaddr  : m0_bus.awaddr;
   assign own_awprot  = owner_q ? m1_bus.awprot  : m0_bus.awprot;
   assign own_wvalid  = owner_q ? m1_bus.wvalid  : m0_bus.wvalid;
   assign own_wdata   = owner_q ? m1_bus.wdata   : m0_bus.wdata;
   assign own_wstrb   = owner_q ? m1_bus.wstrb   : m0_bus.wstrb;
   assign own_rready  = owner_q ? m1_bus.rready  : m0_bus.rready;
   assign own_bready  = owner_q ? m1_bus.bready  : m0_bus.bready;

   // Owner's response-side signals, routed to the owning port below
   logic                  o_arready, o_awready, o_wready, o_rvalid, o_bvalid;
   logic [DATA_WIDTH-1:0] o_rdata;
   logic [1:0]            o_rresp, o_bresp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b1;
         ar_done_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ar_done_q <= ar_done_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ar_done_d = ar_done_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;

      mem_bus.araddr  = own_araddr;
      mem_bus.arprot  = own_arprot;
      mem_bus.arvalid = 1'b0;
      mem_bus.rready  = 1'b0;
      mem_bus.awaddr  = own_awaddr;
      mem_bus.awprot  = own_awprot;
      mem_bus.awvalid = 1'b0;
      mem_bus.wdata   = own_wdata;
      mem_bus.wstrb   = own_wstrb;
      mem_bus.wvalid  = 1'b0;
      mem_bus.bready  = 1'b0;

      o_arready = 1'b0;
      o_awready = 1'b0;
      o_wready  = 1'b0;
      o_rvalid  = 1'b0;
      o_rdata   = '0;
      o_rresp   = 2'b00;
      o_bvalid  = 1'b0;
      o_bresp   = 2'b00;

      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               owner_d = grant;
               state_d = rd_req[grant] ? RD : WR;
            end
         end
         RD: begin
            mem_bus.arvalid = own_arvalid & ~ar_done_q;
            o_arready       = mem_bus.arready & ~ar_done_q;
            if (own_arvalid && !ar_done_q && mem_bus.arready)
               ar_done_d = 1'b1;
            mem_bus.rready = own_rready;
            o_rvalid       = mem_bus.rvalid;
            o_rdata        = mem_bus.rdata;
            o_rresp        = mem_bus.rresp;
            if (mem_bus.rvalid && own_rready) begin
               state_d   = IDLE;
               ar_done_d = 1'b0;
            end
         end
         WR: begin
            mem_bus.awvalid = own_awvalid & ~aw_done_q;
            o_awready       = mem_bus.awready & ~aw_done_q;
            if (own_awvalid && !aw_done_q && mem_bus.awready)
               aw_done_d = 1'b1;
            mem_bus.wvalid = own_wvalid & ~w_done_q;
            o_wready       = mem_bus.wready & ~w_done_q;
            if (own_wvalid && !w_done_q && mem_bus.wready)
               w_done_d = 1'b1;
            mem_bus.bready = own_bready;
            o_bvalid       = mem_bus.bvalid;
            o_bresp        = mem_bus.bresp;
            if (mem_bus.bvalid && own_bready) begin
               state_d   = IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Non-owner outputs stay at zero so its requests simply wait.
   always_comb begin
      m0_bus.arready = 1'b0;
      m0_bus.awready = 1'b0;
      m0_bus.wready  = 1'b0;
      m0_bus.rvalid  = 1'b0;
      m0_bus.rdata   = '0;
      m0_bus.rresp   = 2'b00;
      m0_bus.bvalid  = 1'b0;
      m0_bus.bresp   = 2'b00;
      m1_bus.arready = 1'b0;
      m1_bus.awready = 1'b0;
      m1_bus.wready  = 1'b0;
      m1_bus.rvalid  = 1'b0;
      m1_bus.rdata   = '0;
      m1_bus.rresp   = 2'b00;
      m1_bus.bvalid  = 1'b0;
      m1_bus.bresp   = 2'b00;
      if (owner_q) begin
         m1_bus.arready = o_arready;
         m1_bus.awready = o_awready;
         m1_bus.wready  = o_wready;
         m1_bus.rvalid  = o_rvalid;
         m1_bus.rdata   = o_rdata;
         m1_bus.rresp   = o_rresp;
         m1_bus.bvalid  = o_bvalid;
         m1_bus.bresp   = o_bresp;
      end else begin
         m0_bus.arready = o_arready;
         m0_bus.awready = o_awready;
         m0_bus.wready  = o_wready;
         m0_bus.rvalid  = o_rvalid;
         m0_bus.rdata   = o_rdata;
         m0_bus.rresp   = o_rresp;
         m0_bus.bvalid  = o_bvalid;
         m0_bus.bresp   = o_bresp;
      end
   end

   assign busy  = (state_q != IDLE);
   assign owner = owner_q;
endmodule

// File: tb/tb_axi4lite_bus_arbiter.sv
// Directed bench for axi4lite_bus_arbiter: two master drivers, a flash-pattern slave model,
// and a scoreboard monitor checking R/B routing, grant order and non-owner isolation.
module tb_axi4lite_bus_arbiter;
   localparam int TMO = 80;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   axi4lite_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) m0_if ();
   axi4lite_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) m1_if ();
   axi4lite_if #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) mem_if ();
   logic busy, owner;

   axi4lite_bus_arbiter #(.ADDR_WIDTH(24), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .m0_bus(m0_if), .m1_bus(m1_if), .mem_bus(mem_if),
      .busy(busy), .owner(owner)
   );

   // Master-side drive arrays, index = port
   logic        arvalid[2], awvalid[2], wvalid[2], rready[2], bready[2];
   logic [23:0] araddr[2], awaddr[2];
   logic [31:0] wdata[2];
   logic        arready_o[2], awready_o[2], wready_o[2], rvalid_o[2], bvalid_o[2];
   logic [31:0] rdata_o[2];
   logic [1:0]  bresp_o[2];

   assign m0_if.arvalid = arvalid[0]; assign m1_if.arvalid = arvalid[1];
   assign m0_if.araddr  = araddr[0];  assign m1_if.araddr  = araddr[1];
   assign m0_if.arprot  = 3'b000;     assign m1_if.arprot  = 3'b000;
   assign m0_if.awvalid = awvalid[0]; assign m1_if.awvalid = awvalid[1];
   assign m0_if.awaddr  = awaddr[0];  assign m1_if.awaddr  = awaddr[1];
   assign m0_if.awprot  = 3'b000;     assign m1_if.awprot  = 3'b000;
   assign m0_if.wvalid  = wvalid[0];  assign m1_if.wvalid  = wvalid[1];
   assign m0_if.wdata   = wdata[0];   assign m1_if.wdata   = wdata[1];
   assign m0_if.wstrb   = 4'hF;       assign m1_if.wstrb   = 4'hF;
   assign m0_if.rready  = rready[0];  assign m1_if.rready  = rready[1];
   assign m0_if.bready  = bready[0];  assign m1_if.bready  = bready[1];

   assign arready_o[0] = m0_if.arready; assign arready_o[1] = m1_if.arready;
   assign awready_o[0] = m0_if.awready; assign awready_o[1] = m1_if.awready;
   assign wready_o[0]  = m0_if.wready;  assign wready_o[1]  = m1_if.wready;
   assign rvalid_o[0]  = m0_if.rvalid;  assign rvalid_o[1]  = m1_if.rvalid;
   assign bvalid_o[0]  = m0_if.bvalid;  assign bvalid_o[1]  = m1_if.bvalid;
   assign rdata_o[0]   = m0_if.rdata;   assign rdata_o[1]   = m1_if.rdata;
   assign bresp_o[0]   = m0_if.bresp;   assign bresp_o[1]   = m1_if.bresp;

   function automatic logic [31:0] flash(input logic [23:0] a);
      logic [7:0] b;
      b = a[7:0] ^ a[15:8] ^ a[23:16];
      return {4{b}};
   endfunction

   // ---------------- slave model ----------------
   int          r_delay = 0, b_delay = 0;
   int          r_cnt, b_cnt, aw_hs_cnt, w_hs_cnt;
   logic        s_rpend, s_rvalid, s_bvalid, aw_got, w_got;
   logic [23:0] s_raddr, last_awaddr;
   logic [31:0] s_rdata, last_wdata;

   assign mem_if.arready = !s_rpend && !s_rvalid;
   assign mem_if.rvalid  = s_rvalid;
   assign mem_if.rdata   = s_rdata;
   assign mem_if.rresp   = 2'b00;
   assign mem_if.awready = !aw_got;
   assign mem_if.wready  = !w_got;
   assign mem_if.bvalid  = s_bvalid;
   assign mem_if.bresp   = 2'b00;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_rpend <= 0; s_rvalid <= 0; s_bvalid <= 0; aw_got <= 0; w_got <= 0;
         r_cnt <= 0; b_cnt <= 0; s_raddr <= '0; s_rdata <= '0;
      end else begin
         if (mem_if.arvalid && mem_if.arready) begin
            s_rpend <= 1; s_raddr <= mem_if.araddr; r_cnt <= 0;
         end
         if (s_rpend && !s_rvalid) begin
            if (r_cnt >= r_delay) begin
               s_rvalid <= 1; s_rdata <= flash(s_raddr); s_rpend <= 0;
            end else r_cnt <= r_cnt + 1;
         end
         if (s_rvalid && mem_if.rready) s_rvalid <= 0;
         if (mem_if.awvalid && mem_if.awready) begin
            aw_got <= 1; last_awaddr <= mem_if.awaddr; aw_hs_cnt <= aw_hs_cnt + 1;
         end
         if (mem_if.wvalid && mem_if.wready) begin
            w_got <= 1; last_wdata <= mem_if.wdata; w_hs_cnt <= w_hs_cnt + 1;
         end
         if (aw_got && w_got && !s_bvalid) begin
            if (b_cnt >= b_delay) begin
               s_bvalid <= 1; aw_got <= 0; w_got <= 0; b_cnt <= 0;
            end else b_cnt <= b_cnt + 1;
         end
         if (s_bvalid && mem_if.bready) s_bvalid <= 0;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
   chk_t        chk_q[$];
   logic [31:0] exp_r0[$], exp_r1[$];
   logic [1:0]  exp_b0[$], exp_b1[$];
   logic        exp_g[$];
   int          n_chk = 0, n_fail = 0;
   logic        busy_q = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_t c;
      c.name = name; c.act = act; c.exp = exp;
      chk_q.push_back(c);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      logic [1:0]  eb;
      while (chk_q.size() > 0) begin
         chk_t c;
         c = chk_q.pop_front();
         cmp(c.name, c.act, c.exp);
      end
      if (!rst) busy_q = 0;
      else begin
         for (int p = 0; p < 2; p++) begin
            if (rvalid_o[p] && rready[p]) begin
               if ((p == 0 ? exp_r0.size() : exp_r1.size()) == 0)
                  cmp(p == 0 ? "unexpected_r_m0" : "unexpected_r_m1", 32'd1, 32'd0);
               else begin
                  e = (p == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
                  cmp(p == 0 ? "rdata_m0" : "rdata_m1", rdata_o[p], e);
               end
            end
            if (bvalid_o[p] && bready[p]) begin
               if ((p == 0 ? exp_b0.size() : exp_b1.size()) == 0)
                  cmp(p == 0 ? "unexpected_b_m0" : "unexpected_b_m1", 32'd1, 32'd0);
               else begin
                  eb = (p == 0) ? exp_b0.pop_front() : exp_b1.pop_front();
                  cmp(p == 0 ? "bresp_m0" : "bresp_m1", 32'(bresp_o[p]), 32'(eb));
               end
            end
         end
         if (busy) begin
            int np;
            np = owner ? 0 : 1;
            cmp("isolation", {rdata_o[np][26:0], arready_o[np], awready_o[np],
                              wready_o[np], rvalid_o[np], bvalid_o[np]}, 32'd0);
         end
         if (busy && !busy_q) begin
            if (exp_g.size() == 0) cmp("unexpected_grant", 32'(owner), 32'd2);
            else cmp("grant_owner", 32'(owner), 32'(exp_g.pop_front()));
         end
         busy_q = busy;
      end
   end

   // ---------------- master drivers ----------------
   task automatic do_read(input int p, input logic [23:0] addr, input logic [31:0] exp);
      int t;
      bit ar_ok, r_ok;
      if (p == 0) exp_r0.push_back(exp); else exp_r1.push_back(exp);
      @(posedge clk); #1;
      arvalid[p] = 1; araddr[p] = addr;
      ar_ok = 0; r_ok = 0; t = 0;
      while (!r_ok && t < TMO) begin
         @(negedge clk);
         if (arvalid[p] && arready_o[p]) ar_ok = 1;
         if (rvalid_o[p] && rready[p]) r_ok = 1;
         @(posedge clk); #1;
         if (ar_ok) arvalid[p] = 0;
         t++;
      end
      if (!r_ok) check("rd_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_write(input int p, input logic [23:0] addr, input logic [31:0] data,
                           input int lead);
      int t;
      bit aw_ok, w_ok, b_ok;
      if (p == 0) exp_b0.push_back(2'b00); else exp_b1.push_back(2'b00);
      @(posedge clk); #1;
      wvalid[p] = 1; wdata[p] = data;
      if (lead == 0) begin awvalid[p] = 1; awaddr[p] = addr; end
      aw_ok = 0; w_ok = 0; b_ok = 0; t = 0;
      while (!b_ok && t < TMO) begin
         @(negedge clk);
         if (awvalid[p] && awready_o[p]) aw_ok = 1;
         if (wvalid[p] && wready_o[p]) w_ok = 1;
         if (bvalid_o[p] && bready[p]) b_ok = 1;
         @(posedge clk); #1;
         t++;
         if (aw_ok) awvalid[p] = 0;
         if (w_ok) wvalid[p] = 0;
         if (t == lead && !aw_ok) begin awvalid[p] = 1; awaddr[p] = addr; end
      end
      if (!b_ok) check("wr_timeout", 32'd1, 32'd0);
   endtask

   task automatic do_reset();
      rst = 0;
      for (int p = 0; p < 2; p++) begin
         arvalid[p] = 0; awvalid[p] = 0; wvalid[p] = 0;
         rready[p] = 1; bready[p] = 1;
         araddr[p] = '0; awaddr[p] = '0; wdata[p] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1;
      @(posedge clk); #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int aw0, w0;
      // Reset state
      do_reset();
      rst = 0;
      #2;
      check("rst_busy_owner", {30'd0, busy, owner}, 32'd1);
      check("rst_valids", 32'({mem_if.arvalid, mem_if.awvalid, mem_if.wvalid, mem_if.rready,
                               mem_if.bready, m0_if.arready, m0_if.awready, m0_if.wready,
                               m1_if.arready, m1_if.awready, m1_if.wready,
                               m0_if.rvalid, m1_if.rvalid, m0_if.bvalid, m1_if.bvalid}), 32'd0);
      do_reset();

      // 1: single m0 read, one-cycle arbitration latency
      exp_g.push_back(1'b0);
      fork
         do_read(0, 24'h000030, 32'h30303030);
         begin
            @(posedge clk); @(negedge clk);
            check("t1_idle_arvalid", {30'd0, mem_if.arvalid, busy}, 32'd0);
            @(negedge clk);
            check("t1_mem_ar", {7'd0, mem_if.arvalid, mem_if.araddr}, 32'h0100_0030);
            check("t1_busy", 32'(busy), 32'd1);
         end
      join
      @(negedge clk);
      check("t1_busy_after", 32'(busy), 32'd0);

      // 2: simultaneous reads after reset -> m0 first
      do_reset();
      exp_g.push_back(1'b0); exp_g.push_back(1'b1);
      fork
         do_read(0, 24'h002211, 32'h33333333);
         do_read(1, 24'h000D1E, 32'h13131313);
      join

      // 3: both ports continuously requesting -> strict alternation
      do_reset();
      for (int i = 0; i < 16; i++) exp_g.push_back(i[0]);
      fork
         for (int i = 0; i < 8; i++) do_read(0, 24'(24'h000100 + i * 24'h010203), flash(24'(24'h000100 + i * 24'h010203)));
         for (int j = 0; j < 8; j++) do_read(1, 24'(24'h0A0000 + j * 24'h000311), flash(24'(24'h0A0000 + j * 24'h000311)));
      join

      // 4: m1 write with W leading AW, slow B; m0 read waits for it
      do_reset();
      b_delay = 5;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      exp_g.push_back(1'b1); exp_g.push_back(1'b0);
      fork
         do_write(1, 24'h000100, 32'hCAFEF00D, 3);
         begin repeat (2) @(posedge clk); do_read(0, 24'h000055, 32'h55555555); end
      join
      check("t4_aw_hs", 32'(aw_hs_cnt - aw0), 32'd1);
      check("t4_w_hs", 32'(w_hs_cnt - w0), 32'd1);
      check("t4_awaddr", 32'(last_awaddr), 32'h00000100);
      check("t4_wdata", last_wdata, 32'hCAFEF00D);
      b_delay = 0;

      // 5: async reset while a read waits for R
      do_reset();
      r_delay = 20;
      exp_g.push_back(1'b0);
      arvalid[0] = 1; araddr[0] = 24'h000040;
      repeat (2) @(posedge clk); #1;
      arvalid[0] = 0;
      repeat (3) @(posedge clk); #2;
      check("t5_busy_pre", 32'(busy), 32'd1);
      rst = 0;
      #1;
      check("t5_async_rst", 32'({busy, owner, mem_if.arvalid, mem_if.rready, mem_if.awvalid,
                                 mem_if.wvalid, mem_if.bready, m0_if.arready, m0_if.rvalid,
                                 m1_if.arready, m1_if.rvalid}), 32'h200);
      r_delay = 0;
      do_reset();
      exp_g.push_back(1'b0);
      do_read(0, 24'h001234, 32'h26262626);

      // 6: m1 read+write together, m0 read slips in between
      do_reset();
      exp_g.push_back(1'b1); exp_g.push_back(1'b0); exp_g.push_back(1'b1);
      fork
         do_read(1, 24'h0ABCDE, 32'h68686868);
         do_write(1, 24'h000200, 32'h12345678, 0);
         begin @(posedge clk); do_read(0, 24'h000777, 32'h70707070); end
      join
      check("t6_awaddr", 32'(last_awaddr), 32'h00000200);
      check("t6_wdata", last_wdata, 32'h12345678);

      check("leftover_r", 32'(exp_r0.size() + exp_r1.size()), 32'd0);
      check("leftover_b", 32'(exp_b0.size() + exp_b1.size()), 32'd0);
      check("leftover_grant", 32'(exp_g.size()), 32'd0);
      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
